// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM state encoding and byte counts.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int BCNT_W     = 2;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(parameter int ADDR_W = 10);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master = loader, slave = byte source / memory side
  modport master (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word shifter; word_full flags the shift that completes a word.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0]       word;
  logic [BCNT_W-1:0] cnt;

  assign word_next = {word[23:0], byte_in};
  assign word_full = shift_en && (cnt == BCNT_W'(WORD_BYTES - 1));

  // Partial words survive rx_valid gaps: state only moves on shift_en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= word_next;
      cnt  <= cnt + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into instruction memory while holding the core.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t         state;
  logic [7:0]     len_hi;
  logic [15:0]    n_words;
  logic [7:0]     xor_acc;
  logic           accept;
  logic [15:0]    len_full;
  logic [ADDR_W:0] wl_next;
  logic [31:0]    word_next;
  logic           word_full;

  assign bus.rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DATA)   || (state == S_CSUM);
  assign accept    = bus.rx_valid && bus.rx_ready;
  assign busy      = (state != S_IDLE);
  assign core_hold = busy;
  assign len_full  = {len_hi, bus.rx_data};
  assign wl_next   = words_loaded + 1'b1;

  word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     ((state == S_IDLE) && start),
    .shift_en  (accept && (state == S_DATA)),
    .byte_in   (bus.rx_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      len_hi         <= '0;
      n_words        <= '0;
      xor_acc        <= '0;
      words_loaded   <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      done        <= 1'b0;
      error       <= 1'b0;
      bus.imem_we <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state        <= S_LEN_HI;
          words_loaded <= '0;
          xor_acc      <= '0;
        end
        S_LEN_HI: if (accept) begin
          len_hi <= bus.rx_data;
          state  <= S_LEN_LO;
        end
        // Oversize loads are rejected here, so imem_addr can never wrap.
        S_LEN_LO: if (accept) begin
          n_words <= len_full;
          if ({1'b0, len_full} > MAX_WORDS) begin
            error <= 1'b1;
            state <= S_IDLE;
          end else if (len_full == 16'd0) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (accept) begin
          xor_acc <= xor_acc ^ bus.rx_data;
          if (word_full) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= words_loaded[ADDR_W-1:0];
            bus.imem_wdata <= word_next;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_loaded <= wl_next;
          state        <= (17'(wl_next) < {1'b0, n_words}) ? S_DATA : S_CSUM;
        end
        S_CSUM: if (accept) begin
          if (bus.rx_data == xor_acc) done  <= 1'b1;
          else                        error <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a stream-parsing reference model.
module tb_program_loader;
  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << ADDR_W;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            core_hold, busy, done, error;
  logic [ADDR_W:0] words_loaded;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]        stream[$];
  int                exp_addr[$];
  logic [31:0]       exp_data[$];
  int                exp_done, exp_err, exp_wl;
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  int                got_done = 0;
  int                got_err  = 0;

  always @(negedge clock) begin
    if (bus.imem_we) begin
      got_addr.push_back(bus.imem_addr);
      got_data.push_back(bus.imem_wdata);
      chk("rdy_in_write", {63'd0, bus.rx_ready}, 64'd0);
    end
    if (done)  got_done++;
    if (error) got_err++;
  end

  // Reference: parse the stream by the protocol rules directly.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_wl   = 0;
    n = int'({stream[0], stream[1]});
    if (n > CAP) begin
      exp_err = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
      for (int k = 0; k < 4; k++) x ^= stream[2+4*i+k];
    end
    exp_wl = n;
    if (stream[2+4*n] == x) exp_done = 1;
    else                    exp_err  = 1;
  endtask

  task automatic build(input int n, input bit bad_csum);
    logic [7:0] x, b;
    x = 8'h00;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        x ^= b;
      end
      stream.push_back(bad_csum ? (x ^ 8'($urandom_range(255, 1))) : x);
    end
  endtask

  task automatic set_fixed(input logic [7:0] csum);
    logic [7:0] f[10];
    f = '{8'h00, 8'h02, 8'h7C, 8'h22, 8'h1A, 8'h14, 8'h48, 8'h00, 8'h00, 8'h10};
    stream.delete();
    foreach (f[i]) stream.push_back(f[i]);
    stream.push_back(csum);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // noisy: also wiggles start mid-load, which the loader must ignore.
  task automatic send_stream(input int max_gap, input bit noisy);
    int gap, t;
    foreach (stream[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clock);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end
      @(negedge clock);
      bus.rx_valid = 1'b1;
      bus.rx_data  = stream[i];
      if (noisy) start = ($urandom_range(3, 0) == 0);
      t = 0;
      while (!bus.rx_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) begin
        chk("rx_ready_timeout", {63'd0, bus.rx_ready}, 64'd1);
        break;
      end
    end
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    start        = 1'b0;
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
    got_done = 0;
    got_err  = 0;
  endtask

  task automatic run_load(input string tag, input int max_gap, input bit noisy);
    int t, m;
    model();
    clear_got();
    do_start();
    send_stream(max_gap, noisy);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clock);
    chk({tag, "_nwr"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
    end
    chk({tag, "_done"}, 64'(got_done), 64'(exp_done));
    chk({tag, "_err"},  64'(got_err),  64'(exp_err));
    chk({tag, "_wl"},   64'(words_loaded), 64'(exp_wl));
    chk({tag, "_hold"}, {63'd0, core_hold}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {63'd0, busy},      64'd0);
    chk({tag, "_hold"},  {63'd0, core_hold}, 64'd0);
    chk({tag, "_rdy"},   {63'd0, bus.rx_ready}, 64'd0);
    chk({tag, "_we"},    {63'd0, bus.imem_we},  64'd0);
    chk({tag, "_addr"},  64'(bus.imem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    chk({tag, "_wl"},    64'(words_loaded),   64'd0);
    chk({tag, "_flags"}, {62'd0, done, error}, 64'd0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);
    chk("por_first_we", {63'd0, bus.imem_we}, 64'd0);

    // Known example: data-byte XOR is 0x08.
    set_fixed(8'h08);
    run_load("ex_good", 2, 1'b0);
    if (got_data.size() == 2) begin
      chk("ex_w0", 64'(got_data[0]), 64'h7C221A14);
      chk("ex_w1", 64'(got_data[1]), 64'h48000010);
    end
    chk("ex_wl2", 64'(words_loaded), 64'd2);

    set_fixed(8'hFF);
    run_load("ex_badcsum", 1, 1'b0);

    stream.delete();
    repeat (3) stream.push_back(8'h00);
    run_load("n0", 1, 1'b0);

    stream.delete();
    stream.push_back(8'h04);
    stream.push_back(8'h01);
    run_load("n1025", 1, 1'b0);

    // Reset after two data bytes, then a clean reload from address 0.
    clear_got();
    set_fixed(8'h08);
    stream = stream[0:3];
    do_start();
    send_stream(0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_we_after", {63'd0, bus.imem_we}, 64'd0);
    chk("midrst_nwr", 64'(got_addr.size()), 64'd0);
    set_fixed(8'h08);
    run_load("after_rst", 1, 1'b0);

    set_fixed(8'h08);
    run_load("contig", 0, 1'b0);

    build(CAP, 1'b0);
    run_load("ncap", 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(4, 0))
        0:       build(CAP + 1 + int'($urandom_range(200, 0)), 1'b0);
        1:       build(int'($urandom_range(6, 0)), 1'b1);
        default: build(int'($urandom_range(8, 0)), 1'b0);
      endcase
      run_load("rand", int'($urandom_range(3, 0)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
